// File: rtl/shift_operand_stage_pkg.sv
// rtl/shift_operand_stage_pkg.sv - shared opcodes, decode constants and buffered entry type
package shift_operand_stage_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Entry fields are sized for the widest legal datapath; narrower builds use the low bits.
  localparam int N_MAX   = 32;
  localparam int SHW_MAX = 5;

  typedef struct packed {
    logic [N_MAX-1:0]   a;
    logic [SHW_MAX-1:0] b;
    logic [1:0]         op;
    logic               ilegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{a: '0, b: '0, op: OP_NONE, ilegal: 1'b0};

endpackage

// File: rtl/shift_operand_stage_if.sv
// rtl/shift_operand_stage_if.sv - upstream issue and downstream shifter handshake bundle
interface shift_operand_stage_if #(
  parameter int N = 32
);

  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] rs1_i;
  logic [N-1:0] rs2_i;
  logic [11:0]  imm_i;
  logic         usa_imm_i;
  logic [2:0]   funct3_i;
  logic [6:0]   funct7_i;

  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] a_o;
  logic [N-1:0] b_o;
  logic [1:0]   operacion_o;
  logic         ilegal_o;
  logic [7:0]   cont_ilegal_o;

  modport slave (
    input  valid_i, rs1_i, rs2_i, imm_i, usa_imm_i, funct3_i, funct7_i, ready_i,
    output ready_o, valid_o, a_o, b_o, operacion_o, ilegal_o, cont_ilegal_o
  );

  modport master (
    output valid_i, rs1_i, rs2_i, imm_i, usa_imm_i, funct3_i, funct7_i, ready_i,
    input  ready_o, valid_o, a_o, b_o, operacion_o, ilegal_o, cont_ilegal_o
  );

endinterface

// File: rtl/shift_operand_stage_decode.sv
// rtl/shift_operand_stage_decode.sv - RV32I shift funct/imm decode and amount masking
module shift_decode
  import shift_operand_stage_pkg::*;
#(
  parameter int N = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic [SHW-1:0] rs2_amt,
  input  logic [11:0]    imm,
  input  logic           usa_imm,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  output logic [SHW-1:0] amt,
  output logic [1:0]     op,
  output logic           ilegal
);

  logic [6:0] f7;

  // Immediate forms carry funct7 in imm[11:5]; amount bits above SHW never reach the shifter.
  always_comb begin
    f7     = usa_imm ? imm[11:5] : funct7;
    amt    = usa_imm ? imm[SHW-1:0] : rs2_amt;
    op     = OP_NONE;
    ilegal = 1'b1;
    if (funct3 == F3_SLL && f7 == F7_BASE) begin
      op     = OP_SLL;
      ilegal = 1'b0;
    end else if (funct3 == F3_SR && f7 == F7_BASE) begin
      op     = OP_SRL;
      ilegal = 1'b0;
    end else if (funct3 == F3_SR && f7 == F7_ALT) begin
      op     = OP_SRA;
      ilegal = 1'b0;
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// rtl/shift_operand_stage.sv - registered shift issue stage with 2-entry skid buffer
module shift_operand_stage
  import shift_operand_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  shift_operand_stage_if.slave bus
);

  localparam int SHW = $clog2(N);

  entry_t         in_entry;
  entry_t         main_q;
  entry_t         skid_q;
  logic           main_valid_q;
  logic           skid_valid_q;
  logic [7:0]     cnt_q;
  logic [SHW-1:0] dec_amt;
  logic [1:0]     dec_op;
  logic           dec_ilegal;
  logic           accept;
  logic           drain;
  logic           unused_rs2_hi;

  shift_decode #(.N(N)) u_decode (
    .rs2_amt (bus.rs2_i[SHW-1:0]),
    .imm     (bus.imm_i),
    .usa_imm (bus.usa_imm_i),
    .funct3  (bus.funct3_i),
    .funct7  (bus.funct7_i),
    .amt     (dec_amt),
    .op      (dec_op),
    .ilegal  (dec_ilegal)
  );

  assign unused_rs2_hi = ^bus.rs2_i[N-1:SHW];

  always_comb begin
    in_entry        = ENTRY_RST;
    in_entry.a      = N_MAX'(bus.rs1_i);
    in_entry.b      = SHW_MAX'(dec_amt);
    in_entry.op     = dec_op;
    in_entry.ilegal = dec_ilegal;
  end

  // ready_o is the inverted skid flag, so ready_i never reaches it combinationally.
  assign accept = bus.valid_i && !skid_valid_q;
  assign drain  = main_valid_q && bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= ENTRY_RST;
      skid_q       <= ENTRY_RST;
    end else if (flush_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || bus.ready_i) begin
        main_q       <= in_entry;
        main_valid_q <= 1'b1;
      end else begin
        skid_q       <= in_entry;
        skid_valid_q <= 1'b1;
      end
    end else if (drain) begin
      main_valid_q <= 1'b0;
    end
  end

  // Flushed accepts are discarded, so they must not be counted either.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'h00;
    end else if (accept && !flush_i && in_entry.ilegal && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'h01;
    end
  end

  assign bus.ready_o       = !skid_valid_q;
  assign bus.valid_o       = main_valid_q;
  assign bus.a_o           = main_q.a[N-1:0];
  assign bus.b_o           = N'(main_q.b);
  assign bus.operacion_o   = main_q.op;
  assign bus.ilegal_o      = main_q.ilegal;
  assign bus.cont_ilegal_o = cnt_q;

endmodule
